// File: rtl/command_processor_if.sv
// Board-side command bus: operator switches and buttons in, three 2-bit
// symbol lanes out toward the bus master/arbiter logic.
interface command_processor_if;
  logic [7:0] switch1;
  logic       button1;
  logic       button2;
  logic       button3;
  logic [1:0] data_read_m1;
  logic [1:0] data_read_m2;
  logic [1:0] data_write;

  // Board / stimulus side: drives the operator controls, observes the lanes.
  modport master (
    output switch1, button1, button2, button3,
    input  data_read_m1, data_read_m2, data_write
  );

  // Command processor side.
  modport slave (
    input  switch1, button1, button2, button3,
    output data_read_m1, data_read_m2, data_write
  );
endinterface

// File: rtl/command_processor.sv
// Two-phase operator command front end: latch an opcode, latch a data byte,
// then serialize the byte MSB first, 2 bits per clock, on the selected lane.
module command_processor (
  input  logic                       clk,
  input  logic                       reset,
  command_processor_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, CMD, SEND} state_t;

  localparam logic [1:0] OP_READ_M1 = 2'b00;
  localparam logic [1:0] OP_READ_M2 = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  state_t     state;
  logic [1:0] opcode;
  logic [7:0] data;
  logic [1:0] cnt;
  logic [2:0] btn;
  logic [2:0] hist;
  logic [2:0] rise;
  logic [1:0] next_sym;
  // Lanes packed as {data_read_m1, data_read_m2, data_write}.
  logic [5:0] lanes_q;

  assign btn  = {bus.button3, bus.button2, bus.button1};
  assign rise = btn & ~hist;

  // Places a symbol on the lane chosen by the opcode; every other lane is 00.
  function automatic logic [5:0] route(input logic [1:0] op, input logic [1:0] sym);
    case (op)
      OP_READ_M1: route = {sym, 2'b00, 2'b00};
      OP_READ_M2: route = {2'b00, sym, 2'b00};
      OP_WRITE:   route = {2'b00, 2'b00, sym};
      default:    route = 6'b0;
    endcase
  endfunction

  // Symbol that follows the one currently on the lane; cnt counts symbols
  // already sent after the first one.
  always_comb begin
    next_sym = 2'b00;
    case (cnt)
      2'd0:    next_sym = data[5:4];
      2'd1:    next_sym = data[3:2];
      2'd2:    next_sym = data[1:0];
      default: next_sym = 2'b00;
    endcase
  end

  // Button history, command FSM and registered lane outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking writes would make rise/FSM order-dependent.
    if (!reset) begin
      // NOTE: history loads the live button level during reset, so a button
      // held through reset is not seen as a fresh press on release.
      hist    <= btn;
      state   <= IDLE;
      opcode  <= 2'b00;
      data    <= 8'h00;
      cnt     <= 2'd0;
      lanes_q <= 6'b0;
    end else begin
      hist    <= btn;
      lanes_q <= 6'b0;
      if (rise[2]) begin
        // Abort wins over everything; latched opcode/data are left as is.
        state <= IDLE;
        cnt   <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (rise[0]) begin
              opcode <= bus.switch1[1:0];
              if (bus.switch1[1:0] != OP_RSVD) state <= CMD;
            end
          end
          CMD: begin
            if (rise[1]) begin
              // Data press beats a simultaneous opcode press; first symbol
              // goes out on this same edge.
              data    <= bus.switch1;
              cnt     <= 2'd0;
              state   <= SEND;
              lanes_q <= route(opcode, bus.switch1[7:6]);
            end else if (rise[0]) begin
              opcode <= bus.switch1[1:0];
              if (bus.switch1[1:0] == OP_RSVD) state <= IDLE;
            end
          end
          SEND: begin
            if (cnt == 2'd3) begin
              state <= IDLE;
              cnt   <= 2'd0;
            end else begin
              cnt     <= cnt + 2'd1;
              lanes_q <= route(opcode, next_sym);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_read_m1 = lanes_q[5:4];
  assign bus.data_read_m2 = lanes_q[3:2];
  assign bus.data_write   = lanes_q[1:0];

endmodule

// File: tb/tb_command_processor.sv
// Scoreboard bench for command_processor: each clock step pushes the lane
// values expected after that edge, then pops and compares them at edge + 1.
module tb_command_processor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  logic [5:0] exp_q[$];

  command_processor_if bus_if ();

  command_processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %b expected %b", tag, cycle, got, exp);
    end
  endtask

  // Expected lanes {m1, m2, write} for a symbol on a given opcode's lane.
  function automatic logic [5:0] lane_of(input logic [1:0] op, input logic [1:0] sym);
    case (op)
      2'b00:   return {sym, 4'b0000};
      2'b01:   return {2'b00, sym, 2'b00};
      2'b10:   return {4'b0000, sym};
      default: return 6'b0;
    endcase
  endfunction

  // One clock: queue expectation, clock, then compare the popped entry.
  task automatic tick(input logic [5:0] exp);
    logic [5:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cycle++;
    e = exp_q.pop_front();
    check("data_read_m1", {6'b0, bus_if.data_read_m1}, {6'b0, e[5:4]});
    check("data_read_m2", {6'b0, bus_if.data_read_m2}, {6'b0, e[3:2]});
    check("data_write",   {6'b0, bus_if.data_write},   {6'b0, e[1:0]});
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(6'b0);
  endtask

  task automatic press_cmd(input logic [7:0] sw);
    bus_if.switch1 = sw;
    bus_if.button1 = 1'b1;
    tick(6'b0);
    bus_if.button1 = 1'b0;
    tick(6'b0);
  endtask

  // Press data button and expect the full 4-symbol frame, then a 00 cycle.
  task automatic send_frame(input logic [1:0] op, input logic [7:0] d);
    logic [7:0] sh;
    bus_if.switch1 = d;
    bus_if.button2 = 1'b1;
    sh = d;
    for (int i = 0; i < 4; i++) begin
      tick(lane_of(op, sh[7:6]));
      bus_if.button2 = 1'b0;
      sh = sh << 2;
    end
    tick(6'b0);
  endtask

  task automatic press_data_no_effect(input logic [7:0] d);
    bus_if.switch1 = d;
    bus_if.button2 = 1'b1;
    tick(6'b0);
    bus_if.button2 = 1'b0;
    idle_ticks(4);
  endtask

  initial begin
    reset          = 1'b0;
    bus_if.switch1 = 8'h00;
    bus_if.button1 = 1'b0;
    bus_if.button2 = 1'b0;
    bus_if.button3 = 1'b0;

    // Reset with buttons low.
    idle_ticks(2);

    // button1 held through reset and after release: no opcode latch.
    bus_if.switch1 = 8'h02;
    bus_if.button1 = 1'b1;
    tick(6'b0);
    reset = 1'b1;
    idle_ticks(2);
    press_data_no_effect(8'hFF);
    bus_if.button1 = 1'b0;
    tick(6'b0);

    // Write frame: 10,10,10,10.
    press_cmd(8'h02);
    send_frame(2'b10, 8'b1010_1010);

    // Read M1 frame: 11,10,01,00.
    press_cmd(8'h00);
    send_frame(2'b00, 8'b1110_0100);

    // Read M2 with abort after two symbols.
    press_cmd(8'h01);
    bus_if.switch1 = 8'hFF;
    bus_if.button2 = 1'b1;
    tick(lane_of(2'b01, 2'b11));
    bus_if.button2 = 1'b0;
    tick(lane_of(2'b01, 2'b11));
    bus_if.button3 = 1'b1;
    tick(6'b0);
    bus_if.button3 = 1'b0;
    tick(6'b0);
    press_data_no_effect(8'hFF);

    // Reserved opcode then data press: nothing.
    press_cmd(8'h03);
    press_data_no_effect(8'h5A);

    // Data press in IDLE: nothing.
    press_data_no_effect(8'hC3);

    // Simultaneous button1/button2 in IDLE: only CMD entered, no chaining.
    bus_if.switch1 = 8'h02;
    bus_if.button1 = 1'b1;
    bus_if.button2 = 1'b1;
    tick(6'b0);
    bus_if.button1 = 1'b0;
    bus_if.button2 = 1'b0;
    idle_ticks(2);
    send_frame(2'b10, 8'b0110_1001);

    // Simultaneous presses in CMD: data wins even though switch bits 1:0 = 11.
    press_cmd(8'h02);
    bus_if.button1 = 1'b1;
    send_frame(2'b10, 8'b1100_0011);
    bus_if.button1 = 1'b0;
    tick(6'b0);

    // Opcode re-latch in CMD, then reserved re-latch returns to IDLE.
    press_cmd(8'h02);
    press_cmd(8'h01);
    send_frame(2'b01, 8'b0001_1011);
    press_cmd(8'h00);
    press_cmd(8'h03);
    press_data_no_effect(8'hFF);

    // Mid-frame reset: one symbol 01, then 00, FSM back in IDLE.
    press_cmd(8'h02);
    bus_if.switch1 = 8'b0101_0101;
    bus_if.button2 = 1'b1;
    tick(lane_of(2'b10, 2'b01));
    bus_if.button2 = 1'b0;
    reset = 1'b0;
    tick(6'b0);
    reset = 1'b1;
    idle_ticks(3);
    press_data_no_effect(8'hFF);
    press_cmd(8'h00);
    send_frame(2'b00, 8'b1001_0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/command_processor.md
Name: command_processor

Overview:
- Operator-facing command front end for the system bus.
- Takes an 8-bit switch bank and three debounced pushbuttons, and accepts a two-phase command: opcode, then data byte.
- Serializes the data byte, 2 bits per clock, MSB first, onto one of three 2-bit lanes: master-1 read, master-2 read, or write.
- Sits between the board I/O and the bus master/arbiter logic.

Parameters:
None. Data byte is fixed at 8 bits, lanes at 2 bits, frame length at 4 symbols.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
switch1  input  8  operator switch bank; carries opcode (bits 1:0) or data byte
button1  input  1  command button, level; rising edge latches opcode
button2  input  1  data button, level; rising edge latches data byte and starts transmission
button3  input  1  abort button, level; rising edge cancels any command
data_read_m1  output  2  registered symbol lane, read command to master 1
data_read_m2  output  2  registered symbol lane, read command to master 2
data_write  output  2  registered symbol lane, write command/data

Behaviour:
- Edge detect: each button has a history flop. rise = button & ~history. History updates every cycle. While reset=0, history loads the current button level, so a button held through reset produces no edge.
- Reset (reset=0 at a clk edge):
  - state=IDLE; opcode=0; data=0; symbol counter=0.
  - All three outputs = 2'b00 from that edge onward.
- States: IDLE, CMD, SEND.
- IDLE:
  - button1 rise: latch opcode=switch1[1:0].
  - Opcode 00, 01 or 10: go to CMD.
  - Opcode 11 is reserved: stay in IDLE, no output activity.
  - button2 rise in IDLE is ignored.
- CMD:
  - button2 rise: latch data=switch1 and go to SEND with counter=0.
  - In the same edge, the first symbol data[7:6] is registered onto the selected lane.
  - button1 rise in CMD re-latches the opcode; reserved opcode 11 returns to IDLE.
- SEND:
  - Edge N (the button2 rise edge) outputs data[7:6]; N+1 outputs data[5:4]; N+2 outputs data[3:2]; N+3 outputs data[1:0].
  - At edge N+4 the lane returns to 00 and the state returns to IDLE.
  - Frame is exactly 4 cycles.
  - button1 and button2 rises during SEND are ignored.
- Lane select: opcode 00 → data_read_m1; 01 → data_read_m2; 10 → data_write. Non-selected lanes stay 00 at all times.
- button3 rise: highest priority in any state. Next edge: state=IDLE, all outputs 00, counter=0. Latched opcode and data are kept but not used.
- Simultaneous rises on the same edge:
  - button3 beats everything.
  - In IDLE, button1 beats button2; button2 is dropped, no chaining.
  - In CMD, button2 beats button1.
- Reset mid-frame: frame truncated immediately, outputs 00 at the reset edge.
- Outputs are purely registered; no combinational path from inputs to outputs.
- A symbol value of 00 is legal data. Framing is implied by the 4-cycle window.

Test Plan:
- Reset: hold reset=0 for 2 cycles with buttons at 0 → all outputs 00, state IDLE. Assert reset with button1 held high, release, keep button1 high → no opcode latch.
- Write: switch1=8'b00000010, pulse button1; then switch1=8'b10101010, pulse button2 → data_write = 10,10,10,10 on edges N..N+3, then 00. Read lanes stay 00.
- Read M1: opcode 00, data 8'b11100100 → data_read_m1 = 11,10,01,00 on consecutive cycles. data_read_m2 and data_write stay 00.
- Read M2 with abort: opcode 01, data 8'b11111111, button3 rise after 2 symbols → data_read_m2 = 11,11, then 00. Next button2 rise is ignored until a new button1 rise.
- Reserved/ignored: opcode 11 then button2 → no output activity. button2 rise in IDLE → nothing. button1 and button2 rising on the same edge in IDLE → only CMD entered.
- Mid-frame reset: start write of 8'b01010101, assert reset after first symbol → data_write = 01 for one cycle, then 00. State IDLE after reset release.
